cmp_frame_tracker: RTL and testbench

//  Streaming, parametrised magnitude comparator. Accepts a frame of (a,b) operand pairs

---
 rtl/cmp_pkg.sv | 13 +
 rtl/cmp_pair.sv | 25 ++
 rtl/cmp_frame_tracker.sv | 145 ++++++++++++++
 tb/tb_cmp_frame_tracker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the frame-level magnitude comparator: FSM states and mode encoding.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/cmp_pair.sv
// Combinational pair compare: greater/equal flags and the winning operand for max or min.
// On a tie the winner is operand a.
module cmp_pair
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] win
);

  logic lt_s;

  assign gt   = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
  assign eq   = (a == b);
  assign lt_s = ~gt & ~eq;
  // b only wins when strictly better, so ties resolve to a
  assign win  = (mode == MODE_MAX) ? (lt_s ? b : a) : (gt ? b : a);

endmodule

// File: rtl/cmp_frame_tracker.sv
// Frame tracker: accepts (a,b) beats, keeps the running extreme and saturating
// beat/eq/gt counters, and presents one registered result per frame.
module cmp_frame_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ext,
  output logic [CNT_W-1:0] out_beats,
  output logic [CNT_W-1:0] out_eq,
  output logic [CNT_W-1:0] out_gt
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  state_t           state_r;
  logic             mode_r;
  logic [WIDTH-1:0] ext_r;
  logic [CNT_W-1:0] beats_r, eq_r, gt_r;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] out_ext_r;
  logic [CNT_W-1:0] out_beats_r, out_eq_r, out_gt_r;

  logic             first_s, accept_s, mode_eff_s;
  logic             pair_gt_s, pair_eq_s;
  logic [WIDTH-1:0] pair_win_s, keep_win_s, ext_nxt_s;
  logic             ext_gt_unused_s, ext_eq_unused_s;
  logic [CNT_W-1:0] beats_nxt_s, eq_nxt_s, gt_nxt_s;

  assign first_s    = (state_r == IDLE);
  assign accept_s   = in_valid & in_ready_r;
  assign mode_eff_s = first_s ? mode : mode_r;

  cmp_pair #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_pair (
    .a(in_a), .b(in_b), .mode(mode_eff_s),
    .gt(pair_gt_s), .eq(pair_eq_s), .win(pair_win_s)
  );

  // Running extreme on the a side so ties keep the stored value
  cmp_pair #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_ext (
    .a(ext_r), .b(pair_win_s), .mode(mode_eff_s),
    .gt(ext_gt_unused_s), .eq(ext_eq_unused_s), .win(keep_win_s)
  );

  // Next accumulator values for an accepted beat; the first beat restarts the frame
  always_comb begin
    ext_nxt_s   = keep_win_s;
    beats_nxt_s = sat_inc(beats_r, 1'b1);
    eq_nxt_s    = sat_inc(eq_r, pair_eq_s);
    gt_nxt_s    = sat_inc(gt_r, pair_gt_s);
    if (first_s) begin
      ext_nxt_s   = pair_win_s;
      beats_nxt_s = CNT_ONE;
      eq_nxt_s    = pair_eq_s ? CNT_ONE : CNT_ZERO;
      gt_nxt_s    = pair_gt_s ? CNT_ONE : CNT_ZERO;
    end else begin
      ext_nxt_s   = keep_win_s;
    end
  end

  // Frame FSM with accumulators and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mode_r      <= MODE_MAX;
      ext_r       <= {WIDTH{1'b0}};
      beats_r     <= CNT_ZERO;
      eq_r        <= CNT_ZERO;
      gt_r        <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_ext_r   <= {WIDTH{1'b0}};
      out_beats_r <= CNT_ZERO;
      out_eq_r    <= CNT_ZERO;
      out_gt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE, ACC: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            ext_r   <= ext_nxt_s;
            beats_r <= beats_nxt_s;
            eq_r    <= eq_nxt_s;
            gt_r    <= gt_nxt_s;
            if (first_s) begin
              mode_r <= mode;
            end
            if (in_last) begin
              state_r     <= DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_ext_r   <= ext_nxt_s;
              out_beats_r <= beats_nxt_s;
              out_eq_r    <= eq_nxt_s;
              out_gt_r    <= gt_nxt_s;
            end else begin
              state_r <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_ext   = out_ext_r;
  assign out_beats = out_beats_r;
  assign out_eq    = out_eq_r;
  assign out_gt    = out_gt_r;

endmodule

// File: tb/tb_cmp_frame_tracker.sv
// Scoreboard bench: three tracker instances (unsigned, signed, 2-bit counters) share
// operand buses; expected results are queued at stimulus time and popped by a monitor.
module tb_cmp_frame_tracker;

  typedef struct {
    logic [7:0] ext;
    logic [7:0] beats;
    logic [7:0] eq;
    logic [7:0] gt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] vld;
  logic [7:0] a, b;
  logic       last, mode, ordy;

  logic       rdy [3];
  logic       ov  [3];
  logic [7:0] ext [3];
  logic [7:0] bts [3];
  logic [7:0] eqc [3];
  logic [7:0] gtc [3];
  logic [1:0] b2, e2, g2;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_frame_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(a), .in_b(b), .in_last(last), .mode(mode),
    .out_valid(ov[0]), .out_ready(ordy), .out_ext(ext[0]),
    .out_beats(bts[0]), .out_eq(eqc[0]), .out_gt(gtc[0])
  );

  cmp_frame_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(a), .in_b(b), .in_last(last), .mode(mode),
    .out_valid(ov[1]), .out_ready(ordy), .out_ext(ext[1]),
    .out_beats(bts[1]), .out_eq(eqc[1]), .out_gt(gtc[1])
  );

  cmp_frame_tracker #(.WIDTH(8), .CNT_W(2), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_a(a), .in_b(b), .in_last(last), .mode(mode),
    .out_valid(ov[2]), .out_ready(ordy), .out_ext(ext[2]),
    .out_beats(b2), .out_eq(e2), .out_gt(g2)
  );

  assign bts[2] = {6'd0, b2};
  assign eqc[2] = {6'd0, e2};
  assign gtc[2] = {6'd0, g2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input int i, input logic [7:0] e, input logic [7:0] n,
                      input logic [7:0] q, input logic [7:0] g);
    exp_t x;
    x.ext = e; x.beats = n; x.eq = q; x.gt = g;
    case (i)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic send(input int i, input logic [7:0] aa, input logic [7:0] bb,
                      input logic l, input logic m);
    int n;
    n = 0;
    a = aa; b = bb; last = l; mode = m;
    while (!rdy[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[i]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: instance %0d never ready", i);
    end
    vld[i] = 1'b1;
    @(posedge clk); #1;
    vld[i] = 1'b0;
  endtask

  // Monitor: compare each presented result against the head of its queue
  always @(negedge clk) begin
    if (rst_n && ordy) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          exp_t e;
          bit have;
          have = 1'b0;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: instance %0d ext %0h", i, ext[i]);
          end else begin
            chk($sformatf("ext[%0d]", i),   {24'd0, ext[i]}, {24'd0, e.ext});
            chk($sformatf("beats[%0d]", i), {24'd0, bts[i]}, {24'd0, e.beats});
            chk($sformatf("eq[%0d]", i),    {24'd0, eqc[i]}, {24'd0, e.eq});
            chk($sformatf("gt[%0d]", i),    {24'd0, gtc[i]}, {24'd0, e.gt});
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queues_drained", q0.size() + q1.size() + q2.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; vld = 3'b000; a = 8'd0; b = 8'd0; last = 1'b0; mode = 1'b0; ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_in_ready0", {31'd0, rdy[0]}, 32'd0);
    chk("rst_in_ready2", {31'd0, rdy[2]}, 32'd0);
    chk("rst_out_ext", {24'd0, ext[0]}, 32'd0);
    chk("rst_out_beats", {24'd0, bts[1]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {31'd0, rdy[0]}, 32'd1);

    // Unsigned max frame
    push(0, 8'd200, 8'd3, 8'd1, 8'd1);
    send(0, 8'd3, 8'd5, 1'b0, 1'b0);
    send(0, 8'd9, 8'd9, 1'b0, 1'b0);
    send(0, 8'd200, 8'd7, 1'b1, 1'b0);
    chk("latency_valid", {31'd0, ov[0]}, 32'd1);
    drain();

    // Signed min and signed max
    push(1, 8'h80, 8'd2, 8'd0, 8'd0);
    send(1, 8'h80, 8'h7F, 1'b0, 1'b1);
    send(1, 8'hFF, 8'h01, 1'b1, 1'b1);
    push(1, 8'h7F, 8'd1, 8'd0, 8'd1);
    send(1, 8'h7F, 8'h80, 1'b1, 1'b0);
    // Unsigned min on the same pattern picks the other operand
    push(0, 8'h7F, 8'd1, 8'd0, 8'd1);
    send(0, 8'h80, 8'h7F, 1'b1, 1'b1);
    drain();

    // Single-beat frame with next-cycle result
    push(0, 8'd4, 8'd1, 8'd1, 8'd0);
    send(0, 8'd4, 8'd4, 1'b1, 1'b0);
    chk("single_beat_valid", {31'd0, ov[0]}, 32'd1);
    chk("single_beat_in_ready", {31'd0, rdy[0]}, 32'd0);
    drain();

    // Back-pressure: result held for 10 cycles while input pulses are ignored
    ordy = 1'b0;
    push(0, 8'd200, 8'd3, 8'd1, 8'd1);
    send(0, 8'd3, 8'd5, 1'b0, 1'b0);
    send(0, 8'd9, 8'd9, 1'b0, 1'b0);
    send(0, 8'd200, 8'd7, 1'b1, 1'b0);
    a = 8'd255; b = 8'd0; last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vld[0] = k[0];
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, ov[0]}, 32'd1);
      chk("hold_in_ready", {31'd0, rdy[0]}, 32'd0);
      chk("hold_ext", {24'd0, ext[0]}, 32'd200);
      chk("hold_beats", {24'd0, bts[0]}, 32'd3);
    end
    vld[0] = 1'b0;
    ordy = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("valid_drops", {31'd0, ov[0]}, 32'd0);
    chk("in_ready_back", {31'd0, rdy[0]}, 32'd1);

    // Mode toggled mid-frame: min latched on first beat stays in force
    push(0, 8'd3, 8'd2, 8'd0, 8'd1);
    send(0, 8'd5, 8'd3, 1'b0, 1'b1);
    send(0, 8'd10, 8'd20, 1'b1, 1'b0);
    drain();

    // 2-bit counters saturate at 3
    push(2, 8'd7, 8'd3, 8'd3, 8'd0);
    for (int k = 0; k < 5; k++) begin
      send(2, 8'd7, 8'd7, (k == 4) ? 1'b1 : 1'b0, 1'b0);
    end
    drain();

    // Reset mid-frame discards the partial frame
    send(0, 8'd50, 8'd60, 1'b0, 1'b0);
    send(0, 8'd70, 8'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, ov[0]}, 32'd0);
    chk("midrst_in_ready", {31'd0, rdy[0]}, 32'd0);
    chk("midrst_ext", {24'd0, ext[0]}, 32'd0);
    rst_n = 1'b1;
    push(0, 8'd2, 8'd1, 8'd0, 8'd0);
    send(0, 8'd1, 8'd2, 1'b1, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
